// File: rtl/params_noc.sv
// Shared NoC parameters: port numbering, flit labels and switch-allocator state types.
package params_noc;

    localparam int in_Port_Cnt     = 5;  // LOCAL, NORTH, EAST, SOUTH, WEST
    localparam int in_port_Size    = 3;  // bits to index an input port
    localparam int inout_Port      = 3;  // bits of a requested output port
    localparam int flit_Data_Label = 2;  // bits of a flit label

    typedef enum logic [inout_Port-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef enum logic [flit_Data_Label-1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_e;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

    typedef struct packed {
        alloc_state_e            state;
        logic [in_port_Size-1:0] owner;
        logic [in_port_Size-1:0] ptr;
    } out_ctx_t;

    // Labels that may open a packet (and therefore win an idle output).
    function automatic logic is_head(input logic [flit_Data_Label-1:0] lbl);
        return (lbl == HEAD) || (lbl == HEADTAIL);
    endfunction

    function automatic logic [in_port_Size-1:0] rr_next(input logic [in_port_Size-1:0] idx);
        return (idx == 3'd4) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 5-way round-robin pick: first request at ptr, ptr+1, ... wrapping 4 -> 0.
module rr_arbiter
    import params_noc::*;
(
    input  logic [in_Port_Cnt-1:0]  req,
    input  logic [in_port_Size-1:0] ptr,
    output logic [in_Port_Cnt-1:0]  gnt,
    output logic [in_port_Size-1:0] idx,
    output logic                    any
);

    logic [in_port_Size-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < in_Port_Cnt; k++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter and lock per output port.
// Optional SWITCH_ALLOC_ERR_CNT_EN adds a saturating protocol-error cycle counter (err_cnt_o).
module switch_allocator
    import params_noc::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [in_Port_Cnt-1:0]                   req_valid_i,
    input  logic [in_Port_Cnt-1:0][inout_Port-1:0]   req_port_i,
    input  logic [in_Port_Cnt-1:0][flit_Data_Label-1:0] req_label_i,
    input  logic [in_Port_Cnt-1:0]                   out_ready_i,
    output logic [in_Port_Cnt-1:0]                   grant_o,
    output logic [in_Port_Cnt-1:0][in_port_Size-1:0] xbar_sel_o,
    output logic [in_Port_Cnt-1:0]                   xbar_valid_o
`ifdef SWITCH_ALLOC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]                     err_cnt_o
`endif
);

    logic [in_Port_Cnt-1:0][in_Port_Cnt-1:0] gnt_vec;  // [output][input]
`ifdef SWITCH_ALLOC_ERR_CNT_EN
    logic [in_Port_Cnt-1:0] viol_vec;
`endif

    for (genvar o = 0; o < in_Port_Cnt; o++) begin : g_out
        out_ctx_t                ctx_q, ctx_d;
        logic [in_Port_Cnt-1:0]  hit, elig, arb_gnt, gv;
        logic [in_port_Size-1:0] arb_idx, sel;
        logic                    arb_any, vld;

        always_comb begin
            for (int i = 0; i < in_Port_Cnt; i++) begin
                hit[i]  = req_valid_i[i] && (req_port_i[i] == inout_Port'(o));
                elig[i] = hit[i] && is_head(req_label_i[i]);
            end
        end

        rr_arbiter u_arb (
            .req (elig),
            .ptr (ctx_q.ptr),
            .gnt (arb_gnt),
            .idx (arb_idx),
            .any (arb_any)
        );

        // Grants are gated by rst so nothing leaves while the lock state is being cleared.
        always_comb begin
            ctx_d = ctx_q;
            vld   = 1'b0;
            sel   = '0;
            gv    = '0;
            if (!rst && out_ready_i[o]) begin
                if (ctx_q.state == ALLOC_IDLE) begin
                    if (arb_any) begin
                        vld       = 1'b1;
                        sel       = arb_idx;
                        gv        = arb_gnt;
                        ctx_d.ptr = rr_next(arb_idx);
                        if (req_label_i[arb_idx] == HEAD) begin
                            ctx_d.state = ALLOC_LOCKED;
                            ctx_d.owner = arb_idx;
                        end
                    end
                end else if (hit[ctx_q.owner] && !is_head(req_label_i[ctx_q.owner])) begin
                    vld              = 1'b1;
                    sel              = ctx_q.owner;
                    gv[ctx_q.owner]  = 1'b1;
                    if (req_label_i[ctx_q.owner] == TAIL)
                        ctx_d.state = ALLOC_IDLE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) ctx_q <= '{state: ALLOC_IDLE, owner: '0, ptr: '0};
            else     ctx_q <= ctx_d;
        end

        assign xbar_valid_o[o] = vld;
        assign xbar_sel_o[o]   = sel;
        assign gnt_vec[o]      = gv;

`ifdef SWITCH_ALLOC_ERR_CNT_EN
        logic viol;
        always_comb begin
            viol = 1'b0;
            for (int i = 0; i < in_Port_Cnt; i++) begin
                if (hit[i] && !is_head(req_label_i[i]) &&
                    !(ctx_q.state == ALLOC_LOCKED && ctx_q.owner == in_port_Size'(i)))
                    viol = 1'b1;
            end
            if (ctx_q.state == ALLOC_LOCKED && hit[ctx_q.owner] && is_head(req_label_i[ctx_q.owner]))
                viol = 1'b1;
        end
        assign viol_vec[o] = viol;
`endif
    end

    // Each input names a single output, so at most one column bit is set per input.
    always_comb begin
        grant_o = '0;
        for (int o = 0; o < in_Port_Cnt; o++)
            grant_o = grant_o | gnt_vec[o];
    end

`ifdef SWITCH_ALLOC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                err_cnt_o <= '0;
        else if (|viol_vec && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
`else
    // Keeps ERR_CNT_W referenced in builds without the counter.
    logic [ERR_CNT_W-1:0] unused_err_w;
    assign unused_err_w = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus random traffic vs a packet-level model.
module tb_switch_allocator;
    import params_noc::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [4:0]          req_valid;
    logic [4:0][2:0]     req_port;
    logic [4:0][1:0]     req_label;
    logic [4:0]          out_ready;
    logic [4:0]          grant_o;
    logic [4:0][2:0]     xbar_sel_o;
    logic [4:0]          xbar_valid_o;
`ifdef SWITCH_ALLOC_ERR_CNT_EN
    logic [7:0]          err_cnt_o;
`endif

    always #5 clk = ~clk;

    switch_allocator #(.ERR_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_port_i   (req_port),
        .req_label_i  (req_label),
        .out_ready_i  (out_ready),
        .grant_o      (grant_o),
        .xbar_sel_o   (xbar_sel_o),
        .xbar_valid_o (xbar_valid_o)
`ifdef SWITCH_ALLOC_ERR_CNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Packet-level model: which input holds each output, and where its search starts.
    int              m_holder [5];  // -1 when the output is free
    int              m_ptr    [5];
    int              win      [5];
    logic [4:0]      e_gnt, e_xv, last_gnt;
    logic [4:0][2:0] e_sel, last_sel;

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            m_holder[o] = -1;
            m_ptr[o]    = 0;
        end
    endtask

    task automatic model_eval();
        e_gnt = '0; e_xv = '0; e_sel = '0;
        for (int o = 0; o < 5; o++) begin
            win[o] = -1;
            if (!rst && out_ready[o]) begin
                if (m_holder[o] < 0) begin
                    for (int k = 0; k < 5; k++) begin
                        int i;
                        i = (m_ptr[o] + k) % 5;
                        if (win[o] < 0 && req_valid[i] && int'(req_port[i]) == o &&
                            (req_label[i] == HEAD || req_label[i] == HEADTAIL))
                            win[o] = i;
                    end
                end else begin
                    int i;
                    i = m_holder[o];
                    if (req_valid[i] && int'(req_port[i]) == o &&
                        (req_label[i] == BODY || req_label[i] == TAIL))
                        win[o] = i;
                end
            end
            if (win[o] >= 0) begin
                e_gnt[win[o]] = 1'b1;
                e_xv[o]       = 1'b1;
                e_sel[o]      = 3'(win[o]);
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
            return;
        end
        for (int o = 0; o < 5; o++) begin
            if (win[o] >= 0) begin
                if (m_holder[o] < 0) begin
                    m_ptr[o] = (win[o] + 1) % 5;
                    if (req_label[win[o]] == HEAD) m_holder[o] = win[o];
                end else if (req_label[win[o]] == TAIL) begin
                    m_holder[o] = -1;
                end
            end
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".grant"},      32'(grant_o),      32'(e_gnt));
        chk({tag, ".xbar_valid"}, 32'(xbar_valid_o), 32'(e_xv));
        chk({tag, ".xbar_sel"},   32'(xbar_sel_o),   32'(e_sel));
        last_gnt = grant_o;
        last_sel = xbar_sel_o;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        req_valid = '0;
        req_port  = '0;
        req_label = '0;
        out_ready = '1;
    endtask

    task automatic put(input int i, input int p, input flit_label_e l);
        req_valid[i] = 1'b1;
        req_port[i]  = 3'(p);
        req_label[i] = l;
    endtask

    flit_label_e pkt [4] = '{HEAD, BODY, BODY, TAIL};

    initial begin
        model_reset();
        rst = 1'b1;
        idle_in();
        for (int i = 0; i < 5; i++) put(i, i, HEAD);
        #1;
        cyc("rst");
        cyc("rst");
        chk("rst.grant_zero", 32'(last_gnt), 32'h0);
        rst = 1'b0;
        idle_in();
        cyc("post_rst");

        // Contention on EAST between inputs 1 and 3
        put(1, EAST, HEADTAIL);
        put(3, EAST, HEADTAIL);
        for (int k = 0; k < 4; k++) begin
            cyc("contend");
            chk("contend.seq", 32'(last_gnt), (k % 2 == 0) ? 32'h02 : 32'h08);
        end

        // Wormhole lock on SOUTH; input 1 first moves the pointer to 2
        idle_in();
        put(1, SOUTH, HEADTAIL);
        cyc("wh.pre");
        idle_in();
        for (int k = 0; k < 4; k++) begin
            put(2, SOUTH, pkt[k]);
            put(0, SOUTH, HEAD);
            cyc("wh.hold");
            chk("wh.owner", 32'(last_gnt), 32'h04);
        end
        req_valid[2] = 1'b0;
        cyc("wh.next");
        chk("wh.input0", 32'(last_gnt), 32'h01);
        put(0, SOUTH, TAIL);
        cyc("wh.close");

        // Backpressure on a locked WEST
        idle_in();
        put(4, WEST, HEAD);
        cyc("bp.head");
        chk("bp.head_gnt", 32'(last_gnt), 32'h10);
        put(4, WEST, BODY);
        out_ready[WEST] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc("bp.stall");
            chk("bp.stall_gnt", 32'(last_gnt), 32'h0);
        end
        out_ready[WEST] = 1'b1;
        cyc("bp.resume");
        chk("bp.resume_gnt", 32'(last_gnt), 32'h10);
        put(4, WEST, TAIL);
        cyc("bp.tail");

        // Reset in the middle of a packet on NORTH
        idle_in();
        put(1, NORTH, HEAD);
        cyc("mid.head");
        chk("mid.head_gnt", 32'(last_gnt), 32'h02);
        rst = 1'b1;
        put(1, NORTH, BODY);
        cyc("mid.rst");
        rst = 1'b0;
        cyc("mid.body");
        chk("mid.body_blocked", 32'(last_gnt), 32'h0);
        put(1, NORTH, HEADTAIL);
        cyc("mid.reopen");
        chk("mid.reopen_gnt", 32'(last_gnt), 32'h02);

        // All five inputs to distinct outputs
        idle_in();
        for (int i = 0; i < 5; i++) put(i, (i + 1) % 5, HEADTAIL);
        cyc("par");
        chk("par.grant", 32'(last_gnt), 32'h1f);
        for (int o = 0; o < 5; o++)
            chk($sformatf("par.sel%0d", o), 32'(last_sel[o]), 32'((o + 4) % 5));

`ifdef SWITCH_ALLOC_ERR_CNT_EN
        idle_in();
        put(2, EAST, BODY);
        for (int k = 0; k < 300; k++) cyc("viol");
        chk("viol.err_cnt", 32'(err_cnt_o), 32'd255);
`endif

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 5; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                req_port[i]  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                            : 3'($urandom_range(0, 4));
                req_label[i] = 2'($urandom_range(0, 3));
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            cyc("rnd");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the protocol-error counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, in_Port_Cnt, per-input flit waiting at the buffer head.
REQ-005 SHALL have port req_port_i, input, in_Port_Cnt x inout_Port, per-input requested output port.
REQ-006 SHALL have port req_label_i, input, in_Port_Cnt x flit_Data_Label, per-input label of the head flit.
REQ-007 SHALL have port out_ready_i, input, in_Port_Cnt, per-output downstream can accept one flit this cycle.
REQ-008 SHALL have port grant_o, output, in_Port_Cnt, per-input flit departs this cycle (dequeue strobe).
REQ-009 SHALL have port xbar_sel_o, output, in_Port_Cnt x in_port_Size, per-output index of the driving input.
REQ-010 SHALL have port xbar_valid_o, output, in_Port_Cnt, per-output crossbar carries a valid flit this cycle.

Function
REQ-011 SHALL keep, per output, a state in {ALLOC_IDLE, ALLOC_LOCKED}, an owner index and a round-robin pointer (0..4).
REQ-012 Grants SHALL be combinational from the current inputs and registered state (zero-cycle latency); state SHALL update at the next edge.
REQ-013 An output SHALL grant only when out_ready_i for it is 1; otherwise its state, owner and pointer SHALL hold.
REQ-014 In ALLOC_IDLE, eligible requesters SHALL be inputs with valid=1, a matching port, and label HEAD or HEADTAIL; the winner SHALL be the first eligible index searching pointer, pointer+1, ..., with wrap from 4 to 0.
REQ-015 On an IDLE grant of HEAD: state SHALL become ALLOC_LOCKED, owner SHALL equal the winner, and pointer SHALL equal (winner+1) mod 5.
REQ-016 On an IDLE grant of HEADTAIL: state SHALL stay ALLOC_IDLE and pointer SHALL equal (winner+1) mod 5.
REQ-017 In ALLOC_LOCKED, only the owner SHALL be granted, and only for BODY or TAIL; all other requesters for that output SHALL be blocked.
REQ-018 A granted TAIL SHALL return the output to ALLOC_IDLE; the pointer SHALL be unchanged.
REQ-019 req_port_i values above 4 SHALL never be granted.
REQ-020 A protocol violation is any of: BODY/TAIL from a non-owner toward an output; HEAD/HEADTAIL from the owner while locked. A violation SHALL not be granted and SHALL not change state.
REQ-021 grant_o[i] SHALL be 1 exactly when some output selects input i; at most one output SHALL grant per input.
REQ-022 xbar_sel_o[o] SHALL be 0 whenever xbar_valid_o[o]=0.

Reset
REQ-023 While rst=1, every output SHALL be ALLOC_IDLE with owner 0 and pointer 0 (LOCAL highest priority).
REQ-024 While rst=1, grant_o, xbar_valid_o and xbar_sel_o SHALL be 0.
REQ-025 rst asserted mid-packet SHALL drop every lock; the first flit after reset SHALL need HEAD/HEADTAIL to win.

Configuration
REQ-026 With SWITCH_ALLOC_ERR_CNT_EN defined: output err_cnt_o [ERR_CNT_W-1:0] SHALL count cycles with at least one REQ-020 violation, saturate at all-ones, and reset to 0.
REQ-027 Without SWITCH_ALLOC_ERR_CNT_EN: no err_cnt_o port and no counter logic; all other behaviour SHALL be identical.

Structure
REQ-028 Typedef alloc_state_e {ALLOC_IDLE, ALLOC_LOCKED} SHALL be added to package params_noc; in_Port_Cnt, in_port_Size, inout_Port and flit_Data_Label SHALL be taken from that package.
REQ-029 Sub-module rr_arbiter (5-bit request, pointer in, one-hot grant plus index out, purely combinational) SHALL be instantiated once per output.

Verification
REQ-030 Contention: inputs 1 and 3 send HEADTAIL to EAST each cycle, ready=1, pointer 0 -> grants alternate 1,3,1,3; pointer goes 2,4,2.
REQ-031 Wormhole lock: input 2 sends HEAD then BODY,BODY,TAIL to SOUTH while input 0 sends HEAD to SOUTH -> input 2 holds SOUTH for 4 cycles; input 0 is granted in cycle 5.
REQ-032 Backpressure: locked owner with out_ready_i=0 for 3 cycles -> no grant and state held; grant resumes when ready returns to 1.
REQ-033 Reset mid-packet: rst for 1 cycle after a HEAD grant -> output IDLE and pointer 0; a subsequent BODY from the old owner is not granted.
REQ-034 Violation with SWITCH_ALLOC_ERR_CNT_EN: BODY from an unlocked input for 300 cycles -> no grant; err_cnt_o saturates at 255.
REQ-035 Parallel: inputs 0..4 each target a distinct output with HEADTAIL -> all five granted in the same cycle with correct xbar_sel_o.
